// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, port owners,
// and the alignment rule used when a latched request is executed.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, EXEC, MERGE, RESP} state_e;

  typedef enum logic {OWN_C, OWN_D} owner_e;

  // Size 3 is reserved and reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return (size == SZ_H && lsb[0]) || (size == SZ_W && lsb != 2'b00) || (size == 2'd3);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the core port, bit 1 the DMA/debug port.
module rr_arb2
  import dmem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  owner_e last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OWN_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Starts as DMA so the core wins the first tie out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_D;
    end else if (advance && (req != 2'b00)) begin
      last_grant <= grant[1] ? OWN_D : OWN_C;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-requester controller for the single-port data memory: round-robin arbitration,
// load extension, read-modify-write for sub-word stores and misalignment errors.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic              c_req_we,
  input  logic [1:0]        c_req_size,
  input  logic              c_req_unsigned,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  input  logic              c_rsp_ready,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [1:0]        d_req_size,
  input  logic              d_req_unsigned,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  owner_e            owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;

  logic [1:0]        grant;
  logic              mis;
  logic              word_store;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] merged;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({d_req_valid, c_req_valid}),
    .advance (state == IDLE),
    .grant   (grant)
  );

  assign mis        = misaligned(size_q, addr_q[1:0]);
  assign word_store = we_q && (size_q == SZ_W);

  assign c_req_ready = (state == IDLE) && grant[0];
  assign d_req_ready = (state == IDLE) && grant[1];
  assign c_rsp_valid = (state == RESP) && (owner == OWN_C);
  assign d_rsp_valid = (state == RESP) && (owner == OWN_D);

  assign mem_read  = (state == EXEC) && !mis && !word_store;
  assign mem_write = ((state == EXEC) && !mis && word_store) || (state == MERGE);
  assign mem_addr  = (state == EXEC || state == MERGE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = (state == MERGE) ? merge_q : (mem_write ? wdata_q : '0);

  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      SZ_B:    ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Lane replacement for sub-word stores; the untouched lanes come from the EXEC read.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_B) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_C;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (c_req_valid || d_req_valid) begin
            if (grant[1]) begin
              owner   <= OWN_D;
              addr_q  <= d_req_addr;
              we_q    <= d_req_we;
              size_q  <= d_req_size;
              uns_q   <= d_req_unsigned;
              wdata_q <= d_req_wdata;
            end else begin
              owner   <= OWN_C;
              addr_q  <= c_req_addr;
              we_q    <= c_req_we;
              size_q  <= c_req_size;
              uns_q   <= c_req_unsigned;
              wdata_q <= c_req_wdata;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_err   <= mis;
          rsp_rdata <= (!mis && !we_q) ? ld_ext : '0;
          if (!mis && we_q && !word_store) begin
            merge_q <= merged;
            state   <= MERGE;
          end else begin
            state <= RESP;
          end
        end
        MERGE: state <= RESP;
        RESP: begin
          if ((owner == OWN_C) ? c_rsp_ready : d_rsp_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, hand-written arbitration/backpressure/reset
// sequences, and randomized traffic checked against a word-array reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req_valid = 0, c_req_we = 0, c_req_unsigned = 0, c_rsp_ready = 0;
  logic        d_req_valid = 0, d_req_we = 0, d_req_unsigned = 0, d_rsp_ready = 0;
  logic [1:0]  c_req_size = 0, d_req_size = 0;
  logic [31:0] c_req_addr = 0, d_req_addr = 0, c_req_wdata = 0, d_req_wdata = 0;
  logic        c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        rsp_err, mem_read, mem_write;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .c_req_valid    (c_req_valid),
    .c_req_ready    (c_req_ready),
    .c_req_addr     (c_req_addr),
    .c_req_we       (c_req_we),
    .c_req_size     (c_req_size),
    .c_req_unsigned (c_req_unsigned),
    .c_req_wdata    (c_req_wdata),
    .c_rsp_valid    (c_rsp_valid),
    .c_rsp_ready    (c_rsp_ready),
    .d_req_valid    (d_req_valid),
    .d_req_ready    (d_req_ready),
    .d_req_addr     (d_req_addr),
    .d_req_we       (d_req_we),
    .d_req_size     (d_req_size),
    .d_req_unsigned (d_req_unsigned),
    .d_req_wdata    (d_req_wdata),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_ready    (d_rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Behavioural single-port memory: read gated by mem_read, write on the clock edge.
  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference rules, written directly from the access semantics.
  function automatic logic ref_mis(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [7:0] a,
                                           input logic [1:0] sz, input logic uns);
    int unsigned sh, v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      sh = 8 * a[1:0];
      v  = (w >> sh) & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else begin
      sh = 16 * a[1];
      v  = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [7:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
    int unsigned sh, mask;
    if (sz == 2'd2) return wd;
    if (sz == 2'd0) begin
      sh = 8 * a[1:0];
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end
    sh = 16 * a[1];
    mask = 32'hFFFF << sh;
    return (w & ~mask) | ((wd & 32'hFFFF) << sh);
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wt;
    logic        mrd;
    logic        mwr;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        other_v;
    logic        tmo;
  } txn_t;

  task automatic drive(input logic p, input logic v, input logic [7:0] a, input logic we,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd);
    if (!p) begin
      c_req_valid = v; c_req_addr = {24'h0, a}; c_req_we = we;
      c_req_size = sz; c_req_unsigned = uns; c_req_wdata = wd;
    end else begin
      d_req_valid = v; d_req_addr = {24'h0, a}; d_req_we = we;
      d_req_size = sz; d_req_unsigned = uns; d_req_wdata = wd;
    end
  endtask

  // One full transaction on port p; entered and left at posedge+1 with the DUT idle.
  task automatic do_txn(input logic p, input logic [7:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, output txn_t r);
    int n;
    r = '{rdata: 0, err: 0, lat: 0, wt: 0, mrd: 0, mwr: 0, maddr: 0, mwd: 0,
          other_v: 0, tmo: 0};
    drive(p, 1'b1, a, we, sz, uns, wd);
    n = 0;
    @(negedge clk);
    while (!(p ? d_req_ready : c_req_ready) && n < 10) begin
      n++;
      @(negedge clk);
    end
    if (n >= 10) r.tmo = 1;
    r.wt = n;
    @(posedge clk);
    #1;
    drive(p, 1'b0, a, we, sz, uns, wd);
    n = 0;
    @(negedge clk);
    while (!(p ? d_rsp_valid : c_rsp_valid) && n < 10) begin
      if (mem_read) begin r.mrd = 1; r.maddr = mem_addr; end
      if (mem_write) begin r.mwr = 1; r.maddr = mem_addr; r.mwd = mem_wdata; end
      n++;
      @(negedge clk);
    end
    if (n >= 10) r.tmo = 1;
    r.lat = n;
    r.rdata = rsp_rdata;
    r.err = rsp_err;
    r.other_v = p ? c_rsp_valid : d_rsp_valid;
    if (p) d_rsp_ready = 1'b1; else c_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    c_rsp_ready = 1'b0;
    d_rsp_ready = 1'b0;
  endtask

  function automatic void ref_apply(input logic [7:0] a, input logic we, input logic [1:0] sz,
                                    input logic [31:0] wd);
    if (we && !ref_mis(sz, a)) ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], a, sz, wd);
  endfunction

  typedef struct {
    logic        p;
    logic [7:0]  a;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic        exp_mrd;
    logic        exp_mwr;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t vt [18];

  initial begin
    txn_t r;
    int   ng;
    logic grants [4];
    logic saw_wr;
    int   cnt;
    int   n;
    logic [31:0] held;

    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899_AABB;
    ref_mem[4] = 32'h8899_AABB;

    //        p  addr  we sz uns wdata          rdata          err lat rd wr mem wdata
    vt[0]  = '{0, 8'h13, 0, 0, 0, 32'h0,        32'hFFFF_FF88, 0, 1, 1, 0, 32'h0};
    vt[1]  = '{0, 8'h13, 0, 0, 1, 32'h0,        32'h0000_0088, 0, 1, 1, 0, 32'h0};
    vt[2]  = '{0, 8'h12, 0, 1, 0, 32'h0,        32'hFFFF_8899, 0, 1, 1, 0, 32'h0};
    vt[3]  = '{0, 8'h10, 0, 2, 0, 32'h0,        32'h8899_AABB, 0, 1, 1, 0, 32'h0};
    vt[4]  = '{0, 8'h11, 1, 0, 0, 32'h0000_005A, 32'h0,        0, 2, 1, 1, 32'h8899_5ABB};
    vt[5]  = '{0, 8'h10, 0, 2, 0, 32'h0,        32'h8899_5ABB, 0, 1, 1, 0, 32'h0};
    vt[6]  = '{0, 8'h0E, 0, 2, 0, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0};
    vt[7]  = '{0, 8'h11, 1, 1, 0, 32'h0000_1234, 32'h0,        1, 1, 0, 0, 32'h0};
    vt[8]  = '{1, 8'h10, 0, 1, 1, 32'h0,        32'h0000_5ABB, 0, 1, 1, 0, 32'h0};
    vt[9]  = '{1, 8'h10, 0, 3, 0, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0};
    vt[10] = '{1, 8'h12, 1, 1, 0, 32'h0000_1234, 32'h0,        0, 2, 1, 1, 32'h1234_5ABB};
    vt[11] = '{1, 8'h10, 0, 2, 0, 32'h0,        32'h1234_5ABB, 0, 1, 1, 0, 32'h0};
    vt[12] = '{1, 8'h14, 1, 2, 0, 32'hDEAD_BEEF, 32'h0,        0, 1, 0, 1, 32'hDEAD_BEEF};
    vt[13] = '{1, 8'h16, 0, 0, 0, 32'h0,        32'hFFFF_FFAD, 0, 1, 1, 0, 32'h0};
    vt[14] = '{0, 8'h16, 0, 1, 1, 32'h0,        32'h0000_DEAD, 0, 1, 1, 0, 32'h0};
    vt[15] = '{0, 8'h14, 0, 1, 0, 32'h0,        32'hFFFF_BEEF, 0, 1, 1, 0, 32'h0};
    vt[16] = '{0, 8'h17, 1, 0, 0, 32'h1234_5601, 32'h0,        0, 2, 1, 1, 32'h01AD_BEEF};
    vt[17] = '{0, 8'h14, 0, 2, 0, 32'h0,        32'h01AD_BEEF, 0, 1, 1, 0, 32'h0};

    // Reset state.
    #1;
    check("reset_outputs", 32'({c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid,
                                mem_read, mem_write, rsp_err}), 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both ports requesting from reset: core first, then strict alternation.
    drive(1'b0, 1'b1, 8'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 8'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    c_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;
    ng = 0;
    for (int cyc = 0; cyc < 24 && ng < 4; cyc++) begin
      @(negedge clk);
      check("single_ready", 32'(c_req_ready & d_req_ready), 32'h0);
      if (c_rsp_valid || d_rsp_valid)
        check("no_accept_in_resp", 32'({c_req_ready, d_req_ready}), 32'h0);
      if (c_req_ready) begin grants[ng] = 1'b0; ng++; end
      else if (d_req_ready) begin grants[ng] = 1'b1; ng++; end
    end
    check("arb_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) check("arb_order", 32'(grants[i]), 32'(i % 2));
    @(posedge clk);
    #1;
    c_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    c_rsp_ready = 1'b0;
    d_rsp_ready = 1'b0;

    // Directed vector table.
    foreach (vt[i]) begin
      do_txn(vt[i].p, vt[i].a, vt[i].we, vt[i].sz, vt[i].uns, vt[i].wd, r);
      ref_apply(vt[i].a, vt[i].we, vt[i].sz, vt[i].wd);
      if (r.tmo) check("vec_timeout", 32'(r.tmo), 32'h0);
      check("vec_rdata", r.rdata, vt[i].exp_rd);
      check("vec_err", 32'(r.err), 32'(vt[i].exp_err));
      check("vec_latency", 32'(r.lat), 32'(vt[i].exp_lat));
      check("vec_ready_wait", 32'(r.wt), 32'h0);
      check("vec_mem_read", 32'(r.mrd), 32'(vt[i].exp_mrd));
      check("vec_mem_write", 32'(r.mwr), 32'(vt[i].exp_mwr));
      check("vec_other_rsp", 32'(r.other_v), 32'h0);
      if (vt[i].exp_mwr) check("vec_mem_wdata", r.mwd, vt[i].exp_mwd);
      if (vt[i].exp_mrd || vt[i].exp_mwr)
        check("vec_mem_addr", r.maddr, {24'h0, vt[i].a[7:2], 2'b00});
    end

    // Response backpressure on the DMA port while the core is waiting.
    drive(1'b1, 1'b1, 8'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    check("bp_d_ready", 32'(d_req_ready), 32'h1);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    drive(1'b0, 1'b1, 8'h14, 1'b0, 2'd2, 1'b0, 32'h0);
    n = 0;
    @(negedge clk);
    while (!d_rsp_valid && n < 10) begin n++; @(negedge clk); end
    check("bp_rsp_seen", 32'(d_rsp_valid), 32'h1);
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      check("bp_d_rsp_valid", 32'(d_rsp_valid), 32'h1);
      check("bp_rdata_stable", rsp_rdata, ref_mem[4]);
      check("bp_rdata_held", rsp_rdata, held);
      check("bp_c_blocked", 32'({c_req_ready, c_rsp_valid}), 32'h0);
      @(negedge clk);
    end
    d_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    d_rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_after_release", 32'(c_req_ready), 32'h1);
    c_req_valid = 1'b0;
    @(posedge clk);
    #1;
    do_txn(1'b0, 8'h14, 1'b0, 2'd2, 1'b0, 32'h0, r);
    check("bp_core_rdata", r.rdata, ref_mem[5]);

    // Reset asserted while a byte store sits in EXEC: the write must never happen.
    drive(1'b0, 1'b1, 8'h21, 1'b1, 2'd0, 1'b0, 32'h0000_0077);
    @(negedge clk);
    @(posedge clk);
    #1;
    c_req_valid = 1'b0;
    rst_n = 1'b0;
    saw_wr = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 32'({c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid,
                                  mem_read, mem_write, rsp_err}), 32'h0);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (mem_write) saw_wr = 1'b1;
      @(negedge clk);
    end
    check("rst_no_write", 32'(saw_wr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mem_intact", mem[8], ref_mem[8]);
    do_txn(1'b0, 8'h20, 1'b0, 2'd2, 1'b0, 32'h0, r);
    check("rst_after_rdata", r.rdata, ref_mem[8]);
    check("rst_after_wait", 32'(r.wt), 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        p, we, uns;
      logic [7:0]  a;
      logic [1:0]  sz;
      logic [31:0] wd, exp_rd;
      int          exp_lat;
      p   = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd  = $urandom;
      exp_rd  = (we || ref_mis(sz, a)) ? 32'h0 : ref_load(ref_mem[a[7:2]], a, sz, uns);
      exp_lat = (!ref_mis(sz, a) && we && sz != 2'd2) ? 2 : 1;
      do_txn(p, a, we, sz, uns, wd, r);
      ref_apply(a, we, sz, wd);
      if (r.tmo) check("rnd_timeout", 32'(r.tmo), 32'h0);
      check("rnd_rdata", r.rdata, exp_rd);
      check("rnd_err", 32'(r.err), 32'(ref_mis(sz, a)));
      check("rnd_latency", 32'(r.lat), 32'(exp_lat));
    end

    cnt = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) cnt++;
    check("final_mem_words_differing", 32'(cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
